// File: rtl/or_bist_pkg.sv
// Shared definitions for the two-input OR gate BIST: states, vector table
// and the expected-result function.
package or_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } bist_state_t;

  localparam int NUM_VECTORS = 4;
  localparam int CNT_W       = 4;

  // Packed {a,b} per index, index 0 in the low bits: 00, 10, 11, 01.
  localparam logic [2*NUM_VECTORS-1:0] VEC_TABLE = {2'b01, 2'b11, 2'b10, 2'b00};

  function automatic logic [1:0] vec_ab(input logic [1:0] idx);
    return VEC_TABLE[{idx, 1'b0} +: 2];
  endfunction

  function automatic logic expected_y(input logic [1:0] ab);
    return ab[1] | ab[0];
  endfunction

endpackage

// File: rtl/or_bist_settle_timer.sv
// Settle counter: cleared by load, advanced by enable, flags the last
// settle cycle of a vector.
module or_bist_settle_timer
  import or_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_enable,
  output logic o_tc
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_tc = (r_count == CNT_W'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/or_gate_bist.sv
// BIST sequencer for an external two-input OR gate: walks four vectors,
// holds each for SETTLE_CYCLES, samples once and records mismatches.
module or_gate_bist
  import or_bist_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       drv_a,
  output logic       drv_b,
  input  logic       dut_y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_mask
);

  bist_state_t r_state;
  logic [1:0]  r_index;
  logic        r_drv_a;
  logic        r_drv_b;
  logic        r_busy;
  logic        r_done;
  logic        r_pass;
  logic [2:0]  r_err_count;
  logic [3:0]  r_fail_mask;

  logic        w_tc;
  logic        w_tmr_load;
  logic        w_tmr_en;
  logic        w_mismatch;
  logic [1:0]  w_next_ab;

  // Counter is held at zero outside DRIVE so every vector starts fresh.
  assign w_tmr_load = (r_state == ST_IDLE) || (r_state == ST_SAMPLE) || (r_state == ST_DONE);
  assign w_tmr_en   = (r_state == ST_DRIVE);
  assign w_mismatch = (dut_y != expected_y(vec_ab(r_index)));
  assign w_next_ab  = vec_ab(r_index + 2'd1);

  or_bist_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_tmr_load),
    .i_enable(w_tmr_en),
    .o_tc    (w_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_index     <= '0;
      r_drv_a     <= 1'b0;
      r_drv_b     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err_count <= '0;
      r_fail_mask <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start && !abort) begin
            r_state     <= ST_DRIVE;
            r_index     <= '0;
            r_err_count <= '0;
            r_fail_mask <= '0;
            r_pass      <= 1'b0;
            r_busy      <= 1'b1;
            {r_drv_a, r_drv_b} <= vec_ab(2'd0);
          end
        end
        ST_DRIVE, ST_SAMPLE: begin
          if (abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_pass  <= 1'b0;
            r_drv_a <= 1'b0;
            r_drv_b <= 1'b0;
          end else if (r_state == ST_DRIVE) begin
            if (w_tc) begin
              r_state <= ST_SAMPLE;
            end
          end else begin
            if (w_mismatch) begin
              r_fail_mask[r_index] <= 1'b1;
              r_err_count          <= r_err_count + 3'd1;
            end
            if (r_index == 2'(NUM_VECTORS - 1)) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_pass  <= (r_err_count == 3'd0) && !w_mismatch;
              r_drv_a <= 1'b0;
              r_drv_b <= 1'b0;
            end else begin
              r_state <= ST_DRIVE;
              r_index <= r_index + 2'd1;
              {r_drv_a, r_drv_b} <= w_next_ab;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign drv_a     = r_drv_a;
  assign drv_b     = r_drv_b;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_count = r_err_count;
  assign fail_mask = r_fail_mask;

endmodule

// File: tb/tb_or_gate_bist.sv
// Self-checking bench for or_gate_bist: two instances (SETTLE_CYCLES 2 and 1)
// each driven into a modelled gate whose truth table the bench chooses.
module tb_or_gate_bist;

  logic       clk;
  logic       rst_n;
  logic       start_v   [2];
  logic       abort_v   [2];
  logic       drv_a_v   [2];
  logic       drv_b_v   [2];
  logic       dut_y_v   [2];
  logic       busy_v    [2];
  logic       done_v    [2];
  logic       pass_v    [2];
  logic [2:0] err_v     [2];
  logic [3:0] mask_v    [2];
  logic [3:0] tt_v      [2];

  int n_tests = 0;
  int n_fail  = 0;

  // Gate truth tables indexed by {a,b}.
  localparam logic [3:0] TT_OR  = 4'b1110;
  localparam logic [3:0] TT_AND = 4'b1000;
  localparam logic [3:0] TT_S0  = 4'b0000;
  localparam logic [3:0] TT_S1  = 4'b1111;
  localparam logic [3:0] TT_XOR = 4'b0110;
  localparam logic [3:0] TT_NOR = 4'b0001;

  int va [4] = '{0, 1, 1, 0};
  int vb [4] = '{0, 0, 1, 1};

  assign dut_y_v[0] = tt_v[0][{drv_a_v[0], drv_b_v[0]}];
  assign dut_y_v[1] = tt_v[1][{drv_a_v[1], drv_b_v[1]}];

  or_gate_bist #(.SETTLE_CYCLES(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort_v[0]),
    .drv_a(drv_a_v[0]), .drv_b(drv_b_v[0]), .dut_y(dut_y_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
    .err_count(err_v[0]), .fail_mask(mask_v[0])
  );

  or_gate_bist #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort_v[1]),
    .drv_a(drv_a_v[1]), .drv_b(drv_b_v[1]), .dut_y(dut_y_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
    .err_count(err_v[1]), .fail_mask(mask_v[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] tt;
    logic [3:0] exp_mask;
    int         exp_err;
    logic       exp_pass;
  } vec_rec_t;

  vec_rec_t tbl [6];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  // Model: a vector fails when the gate's answer differs from a|b.
  function automatic logic [3:0] model_mask(input logic [3:0] tt);
    logic [3:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      int y;
      y = tt[va[i] * 2 + vb[i]];
      if (y != (va[i] | vb[i])) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic int popcount4(input logic [3:0] m);
    return int'(m[0]) + int'(m[1]) + int'(m[2]) + int'(m[3]);
  endfunction

  // One complete run on instance idx; checks drive sequence, done timing and results.
  task automatic run_check(input int idx, input string name, input logic [3:0] tt,
                           input logic [3:0] exp_mask, input int exp_err, input logic exp_pass);
    int per;
    int drv_bad;
    int done_early;
    per = (idx == 0) ? 3 : 2;
    drv_bad = 0;
    done_early = 0;
    @(negedge clk);
    tt_v[idx] = tt;
    start_v[idx] = 1'b1;
    after_edge();
    start_v[idx] = 1'b0;
    chk({name, " busy_start"}, int'(busy_v[idx]), 1);
    chk({name, " pass_clr"}, int'(pass_v[idx]), 0);
    for (int k = 0; k < 4 * per; k++) begin
      if (int'(drv_a_v[idx]) != va[k / per] || int'(drv_b_v[idx]) != vb[k / per]) drv_bad++;
      if (done_v[idx]) done_early++;
      after_edge();
    end
    chk({name, " drv_seq_errs"}, drv_bad, 0);
    chk({name, " done_early"}, done_early, 0);
    chk({name, " done_at_end"}, int'(done_v[idx]), 1);
    chk({name, " busy_end"}, int'(busy_v[idx]), 0);
    chk({name, " drv_end"}, int'({drv_a_v[idx], drv_b_v[idx]}), 0);
    chk({name, " pass"}, int'(pass_v[idx]), int'(exp_pass));
    chk({name, " err_count"}, int'(err_v[idx]), exp_err);
    chk({name, " fail_mask"}, int'(mask_v[idx]), int'(exp_mask));
    after_edge();
    chk({name, " done_pulse_len"}, int'(done_v[idx]), 0);
    chk({name, " pass_hold"}, int'(pass_v[idx]), int'(exp_pass));
  endtask

  initial begin
    int bad;
    tbl[0] = '{"or",     TT_OR,  4'b0000, 0, 1'b1};
    tbl[1] = '{"stuck0", TT_S0,  4'b1110, 3, 1'b0};
    tbl[2] = '{"and",    TT_AND, 4'b1010, 2, 1'b0};
    tbl[3] = '{"stuck1", TT_S1,  4'b0001, 1, 1'b0};
    tbl[4] = '{"xor",    TT_XOR, 4'b0100, 1, 1'b0};
    tbl[5] = '{"nor",    TT_NOR, 4'b1111, 4, 1'b0};

    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start_v[i] = 1'b0;
      abort_v[i] = 1'b0;
      tt_v[i] = TT_OR;
    end
    #12;
    for (int i = 0; i < 2; i++) begin
      chk("reset_busy", int'(busy_v[i]), 0);
      chk("reset_outs", int'({done_v[i], pass_v[i], drv_a_v[i], drv_b_v[i], err_v[i], mask_v[i]}), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    after_edge();

    for (int t = 0; t < 6; t++) begin
      run_check(0, {"s2_", tbl[t].name}, tbl[t].tt, tbl[t].exp_mask, tbl[t].exp_err, tbl[t].exp_pass);
      run_check(1, {"s1_", tbl[t].name}, tbl[t].tt, tbl[t].exp_mask, tbl[t].exp_err, tbl[t].exp_pass);
    end

    // start held high: first run stuck0, then OR; a single idle cycle between runs
    @(negedge clk);
    tt_v[0] = TT_S0;
    start_v[0] = 1'b1;
    repeat (13) after_edge();
    chk("held done1", int'(done_v[0]), 1);
    chk("held err1", int'(err_v[0]), 3);
    tt_v[0] = TT_OR;
    after_edge();
    chk("held idle_gap", int'(busy_v[0]), 0);
    after_edge();
    chk("held restart_busy", int'(busy_v[0]), 1);
    chk("held err_clr", int'(err_v[0]), 0);
    chk("held mask_clr", int'(mask_v[0]), 0);
    repeat (12) after_edge();
    chk("held done2", int'(done_v[0]), 1);
    chk("held pass2", int'(pass_v[0]), 1);
    repeat (2) after_edge();
    chk("held pass_clr3", int'(pass_v[0]), 0);
    chk("held busy3", int'(busy_v[0]), 1);
    start_v[0] = 1'b0;
    abort_v[0] = 1'b1;
    after_edge();
    abort_v[0] = 1'b0;
    chk("held abort_busy", int'(busy_v[0]), 0);

    // abort at cycle 7 with stuck0: partial counts kept
    @(negedge clk);
    tt_v[0] = TT_S0;
    start_v[0] = 1'b1;
    after_edge();
    start_v[0] = 1'b0;
    repeat (7) after_edge();
    abort_v[0] = 1'b1;
    after_edge();
    abort_v[0] = 1'b0;
    chk("abort busy", int'(busy_v[0]), 0);
    chk("abort drv", int'({drv_a_v[0], drv_b_v[0]}), 0);
    chk("abort pass", int'(pass_v[0]), 0);
    chk("abort err", int'(err_v[0]), 1);
    chk("abort mask", int'(mask_v[0]), 2);
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      if (done_v[0] || busy_v[0]) bad++;
      after_edge();
    end
    chk("abort no_done", bad, 0);

    // abort and start together in idle
    @(negedge clk);
    start_v[0] = 1'b1;
    abort_v[0] = 1'b1;
    after_edge();
    start_v[0] = 1'b0;
    abort_v[0] = 1'b0;
    chk("abort_start busy", int'(busy_v[0]), 0);

    // reset at cycle 5 of a run
    run_check(0, "pre_rst", TT_OR, 4'b0000, 0, 1'b1);
    @(negedge clk);
    tt_v[0] = TT_S0;
    start_v[0] = 1'b1;
    after_edge();
    start_v[0] = 1'b0;
    repeat (5) after_edge();
    rst_n = 1'b0;
    #1;
    chk("rst busy", int'(busy_v[0]), 0);
    chk("rst outs", int'({done_v[0], pass_v[0], drv_a_v[0], drv_b_v[0], err_v[0], mask_v[0]}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      after_edge();
      if (done_v[0] || busy_v[0]) bad++;
    end
    chk("rst no_done", bad, 0);
    run_check(0, "post_rst", TT_AND, 4'b1010, 2, 1'b0);

    // randomized gate faults against the model
    for (int r = 0; r < 16; r++) begin
      logic [3:0] tt;
      logic [3:0] m;
      int inst;
      tt = 4'($urandom_range(0, 15));
      inst = int'($urandom_range(0, 1));
      m = model_mask(tt);
      run_check(inst, "rand", tt, m, popcount4(m), (m == 4'b0000));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
